int_seq_ctrl: RTL and testbench

INT_SEQ_CTRL -- requirements
Module: int_seq_ctrl

---
 rtl/icu_pkg.sv | 22 ++
 rtl/int_seq_ctrl_if.sv | 41 ++++
 rtl/nest_stack.sv | 47 ++++
 rtl/int_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_int_seq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icu_pkg.sv
// rtl/icu_pkg.sv - shared types and constants for the interrupt sequencer
package icu_pkg;

    localparam int VEC_W   = 8;
    localparam int LVL_W   = 3;
    localparam int DEPTH_W = 3;

    localparam logic [1:0] ICU_EOI_ADDR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BND,
        ST_ACK,
        ST_DISPATCH,
        ST_EOI
    } state_e;

    function automatic logic [7:0] lvl_onehot(input logic [LVL_W-1:0] lvl);
        return 8'(1) << lvl;
    endfunction

endpackage

// File: rtl/int_seq_ctrl_if.sv
// rtl/int_seq_ctrl_if.sv - signal bundle around the interrupt sequencer
interface int_seq_ctrl_if;
    import icu_pkg::*;

    logic             intr;
    logic [VEC_W-1:0] vector;
    logic             inta;
    logic             icu_cs;
    logic             icu_we;
    logic [1:0]       icu_addr;
    logic [7:0]       icu_data;
    logic             cpu_cs;
    logic             cpu_we;
    logic [1:0]       cpu_addr;
    logic [7:0]       cpu_data;
    logic             cpu_stall;
    logic             ie;
    logic             instr_done;
    logic             iret;
    logic             int_req;
    logic             vec_valid;
    logic             vec_ready;
    logic [31:0]      handler_addr;
    logic [DEPTH_W-1:0] nest_depth;
    logic             nest_err;

    modport ctrl (
        input  intr, vector, cpu_cs, cpu_we, cpu_addr, cpu_data,
               ie, instr_done, iret, vec_ready,
        output inta, icu_cs, icu_we, icu_addr, icu_data, cpu_stall,
               int_req, vec_valid, handler_addr, nest_depth, nest_err
    );

    modport env (
        output intr, vector, cpu_cs, cpu_we, cpu_addr, cpu_data,
               ie, instr_done, iret, vec_ready,
        input  inta, icu_cs, icu_we, icu_addr, icu_data, cpu_stall,
               int_req, vec_valid, handler_addr, nest_depth, nest_err
    );

endinterface

// File: rtl/nest_stack.sv
// rtl/nest_stack.sv - LIFO of in-service priority levels
module nest_stack
    import icu_pkg::*;
#(
    parameter int MAX_NEST = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [LVL_W-1:0]   i_push_lvl,
    input  logic               i_pop,
    output logic [LVL_W-1:0]   o_top,
    output logic [DEPTH_W-1:0] o_depth
);

    localparam int AW = (MAX_NEST > 1) ? $clog2(MAX_NEST) : 1;

    logic [LVL_W-1:0]   stack_q [MAX_NEST];
    logic [DEPTH_W-1:0] depth_q;
    logic [AW-1:0]      wr_idx;
    logic [AW-1:0]      top_idx;
    logic               full;
    logic               empty;

    assign full    = (depth_q == DEPTH_W'(MAX_NEST));
    assign empty   = (depth_q == '0);
    assign wr_idx  = AW'(depth_q);
    assign top_idx = AW'(depth_q - 1'b1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            depth_q <= '0;
            for (int i = 0; i < MAX_NEST; i++) begin
                stack_q[i] <= '0;
            end
        end else if (i_push && !full) begin
            stack_q[wr_idx] <= i_push_lvl;
            depth_q         <= depth_q + 1'b1;
        end else if (i_pop && !empty) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    assign o_top   = empty ? '0 : stack_q[top_idx];
    assign o_depth = depth_q;

endmodule

// File: rtl/int_seq_ctrl.sv
// rtl/int_seq_ctrl.sv - interrupt acknowledge, vector dispatch and EOI sequencer
module int_seq_ctrl
    import icu_pkg::*;
#(
    parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
    parameter int          INTA_CYCLES = 2,
    parameter int          MAX_NEST    = 4,
    parameter logic [1:0]  EOI_ADDR    = ICU_EOI_ADDR
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_intr,
    input  logic [VEC_W-1:0]   i_vector,
    output logic               o_inta,
    output logic               o_icu_cs,
    output logic               o_icu_we,
    output logic [1:0]         o_icu_addr,
    output logic [7:0]         o_icu_data,
    input  logic               i_cpu_cs,
    input  logic               i_cpu_we,
    input  logic [1:0]         i_cpu_addr,
    input  logic [7:0]         i_cpu_data,
    output logic               o_cpu_stall,
    input  logic               i_ie,
    input  logic               i_instr_done,
    input  logic               i_iret,
    output logic               o_int_req,
    output logic               o_vec_valid,
    input  logic               i_vec_ready,
    output logic [31:0]        o_handler_addr,
    output logic [DEPTH_W-1:0] o_nest_depth,
    output logic               o_nest_err
);

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic [31:0]        handler_q, handler_d;
    logic               pend_q, pend_d;
    logic               err_q, err_d;

    logic               push;
    logic               pop;
    logic [LVL_W-1:0]   top_lvl;
    logic [DEPTH_W-1:0] depth;
    logic               irq_ok;
    logic               below_max;
    logic               ack_last;

    assign irq_ok    = i_intr & i_ie;
    assign below_max = (depth < DEPTH_W'(MAX_NEST));
    assign ack_last  = (cnt_q == 2'(INTA_CYCLES - 1));

    nest_stack #(
        .MAX_NEST (MAX_NEST)
    ) u_stack (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (push),
        .i_push_lvl (lvl_q),
        .i_pop      (pop),
        .o_top      (top_lvl),
        .o_depth    (depth)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lvl_q     <= '0;
            handler_q <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            handler_q <= handler_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lvl_d       = lvl_q;
        handler_d   = handler_q;
        push        = 1'b0;
        pop         = 1'b0;
        o_inta      = 1'b0;
        o_int_req   = 1'b0;
        o_vec_valid = 1'b0;
        o_icu_cs    = i_cpu_cs;
        o_icu_we    = i_cpu_we;
        o_icu_addr  = i_cpu_addr;
        o_icu_data  = i_cpu_data;
        o_cpu_stall = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // a pending EOI waits for a free ICU bus but beats new requests
                if (pend_q && !i_cpu_cs) begin
                    state_d = ST_EOI;
                end else if (irq_ok && below_max) begin
                    state_d = ST_WAIT_BND;
                end
            end
            ST_WAIT_BND: begin
                o_int_req = 1'b1;
                if (i_instr_done) begin
                    state_d = irq_ok ? ST_ACK : ST_IDLE;
                    cnt_d   = '0;
                end else if (!irq_ok) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                o_inta      = 1'b1;
                o_icu_cs    = 1'b0;
                o_icu_we    = 1'b0;
                o_icu_addr  = '0;
                o_icu_data  = '0;
                o_cpu_stall = i_cpu_cs;
                if (ack_last) begin
                    lvl_d     = i_vector[LVL_W-1:0];
                    handler_d = VEC_BASE + {22'b0, i_vector, 2'b00};
                    state_d   = ST_DISPATCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DISPATCH: begin
                o_vec_valid = 1'b1;
                if (i_vec_ready) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EOI: begin
                o_icu_cs    = 1'b1;
                o_icu_we    = 1'b1;
                o_icu_addr  = EOI_ADDR;
                o_icu_data  = lvl_onehot(top_lvl);
                o_cpu_stall = i_cpu_cs;
                pop         = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        pend_d = pend_q;
        err_d  = err_q;
        if (state_q == ST_EOI) begin
            pend_d = 1'b0;
        end
        // a same-cycle push counts as depth, so its EOI pops the new level
        if (i_iret) begin
            if (pend_q || (depth == '0 && !push)) begin
                err_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    assign o_handler_addr = handler_q;
    assign o_nest_depth   = depth;
    assign o_nest_err     = err_q;

endmodule

// File: tb/tb_int_seq_ctrl.sv
// tb/tb_int_seq_ctrl.sv - scoreboard bench for int_seq_ctrl
module tb_int_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] exp_addr_q[$];
    logic [9:0]  exp_bus_q[$];
    logic [31:0] sb_addr;
    logic [9:0]  sb_bus;

    always #5 clk = ~clk;

    int_seq_ctrl_if bus ();

    int_seq_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_intr         (bus.intr),
        .i_vector       (bus.vector),
        .o_inta         (bus.inta),
        .o_icu_cs       (bus.icu_cs),
        .o_icu_we       (bus.icu_we),
        .o_icu_addr     (bus.icu_addr),
        .o_icu_data     (bus.icu_data),
        .i_cpu_cs       (bus.cpu_cs),
        .i_cpu_we       (bus.cpu_we),
        .i_cpu_addr     (bus.cpu_addr),
        .i_cpu_data     (bus.cpu_data),
        .o_cpu_stall    (bus.cpu_stall),
        .i_ie           (bus.ie),
        .i_instr_done   (bus.instr_done),
        .i_iret         (bus.iret),
        .o_int_req      (bus.int_req),
        .o_vec_valid    (bus.vec_valid),
        .i_vec_ready    (bus.vec_ready),
        .o_handler_addr (bus.handler_addr),
        .o_nest_depth   (bus.nest_depth),
        .o_nest_err     (bus.nest_err)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.vec_valid === 1'b1 && bus.vec_ready === 1'b1) begin
                n_checks++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_handler: unexpected handshake addr=%h", bus.handler_addr);
                end else begin
                    sb_addr = exp_addr_q.pop_front();
                    if (bus.handler_addr !== sb_addr) begin
                        n_fail++;
                        $display("FAIL sb_handler: got %h want %h", bus.handler_addr, sb_addr);
                    end
                end
            end
            if (bus.icu_cs === 1'b1 && bus.icu_we === 1'b1) begin
                n_checks++;
                if (exp_bus_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_bus: unexpected write addr=%b data=%h", bus.icu_addr, bus.icu_data);
                end else begin
                    sb_bus = exp_bus_q.pop_front();
                    if ({bus.icu_addr, bus.icu_data} !== sb_bus) begin
                        n_fail++;
                        $display("FAIL sb_bus: got %b/%h want %b/%h", bus.icu_addr, bus.icu_data, sb_bus[9:8], sb_bus[7:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_iret();
        bus.iret = 1'b1;
        tick();
        bus.iret = 1'b0;
    endtask

    task automatic drive_irq(input logic [7:0] v, input bit iret_hs,
                             output int inta_cnt, output logic [31:0] addr, output bit ok);
        ok = 1'b1;
        inta_cnt = 0;
        addr = 'x;
        bus.vector = v;
        bus.intr = 1'b1;
        bus.ie = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.int_req === 1'b1) break;
        end
        if (bus.int_req !== 1'b1) begin
            ok = 1'b0;
            bus.intr = 1'b0;
            return;
        end
        exp_addr_q.push_back(32'h0000_0100 + 32'(v) * 4);
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.vec_valid === 1'b1) break;
            if (bus.inta === 1'b1) inta_cnt++;
        end
        if (bus.vec_valid !== 1'b1) begin
            ok = 1'b0;
            bus.intr = 1'b0;
            return;
        end
        addr = bus.handler_addr;
        tick();
        bus.vec_ready = 1'b1;
        bus.intr = 1'b0;
        bus.iret = iret_hs;
        tick();
        bus.vec_ready = 1'b0;
        bus.iret = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (bus.inta !== 1'b0) begin n_fail++; $display("FAIL reset_inta: got %b want 0", bus.inta); end
        n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req: got %b want 0", bus.int_req); end
        n_checks++; if (bus.vec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vec_valid: got %b want 0", bus.vec_valid); end
        n_checks++; if (bus.handler_addr !== 32'h0) begin n_fail++; $display("FAIL reset_handler: got %h want 0", bus.handler_addr); end
        n_checks++; if (bus.nest_depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", bus.nest_depth); end
        n_checks++; if (bus.nest_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.nest_err); end
        n_checks++; if (bus.icu_cs !== 1'b0) begin n_fail++; $display("FAIL reset_icu_cs: got %b want 0", bus.icu_cs); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic_irq();
        int cnt;
        logic [31:0] addr;
        bit ok;
        tick();
        drive_irq(8'h05, 1'b0, cnt, addr, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: got %b want 1", ok); end
        n_checks++; if (cnt != 2) begin n_fail++; $display("FAIL basic_inta_cycles: got %0d want 2", cnt); end
        n_checks++; if (addr !== 32'h0000_0114) begin n_fail++; $display("FAIL basic_handler: got %h want 00000114", addr); end
        @(negedge clk);
        n_checks++; if (bus.nest_depth !== 3'd1) begin n_fail++; $display("FAIL basic_depth: got %0d want 1", bus.nest_depth); end
    endtask

    task automatic test_eoi();
        int wr = 0;
        logic [1:0] wa = '0;
        logic [7:0] wd = '0;
        tick();
        exp_bus_q.push_back({2'b01, 8'h20});
        do_iret();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.icu_cs === 1'b1 && bus.icu_we === 1'b1) begin
                wr++;
                wa = bus.icu_addr;
                wd = bus.icu_data;
            end
        end
        n_checks++; if (wr != 1) begin n_fail++; $display("FAIL eoi_count: got %0d want 1", wr); end
        n_checks++; if (wa !== 2'b01) begin n_fail++; $display("FAIL eoi_addr: got %b want 01", wa); end
        n_checks++; if (wd !== 8'h20) begin n_fail++; $display("FAIL eoi_data: got %h want 20", wd); end
        n_checks++; if (bus.nest_depth !== 3'd0) begin n_fail++; $display("FAIL eoi_depth: got %0d want 0", bus.nest_depth); end
    endtask

    task automatic test_arbitration();
        tick();
        bus.vector = 8'h0A;
        bus.intr = 1'b1;
        bus.ie = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.int_req === 1'b1) break;
        end
        n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL arb_int_req: got %b want 1", bus.int_req); end
        exp_addr_q.push_back(32'h0000_0128);
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        bus.cpu_cs = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 2'b11;
        bus.cpu_data = 8'h01;
        @(negedge clk);
        n_checks++; if (bus.inta !== 1'b1) begin n_fail++; $display("FAIL arb_in_ack: got %b want 1", bus.inta); end
        n_checks++; if (bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL arb_stall: got %b want 1", bus.cpu_stall); end
        n_checks++; if (bus.icu_cs !== 1'b0) begin n_fail++; $display("FAIL arb_ack_icu_cs: got %b want 0", bus.icu_cs); end
        tick();
        bus.cpu_cs = 1'b0;
        bus.cpu_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.vec_valid === 1'b1) break;
        end
        n_checks++; if (bus.vec_valid !== 1'b1) begin n_fail++; $display("FAIL arb_vec_valid: got %b want 1", bus.vec_valid); end
        tick();
        bus.vec_ready = 1'b1;
        bus.intr = 1'b0;
        tick();
        bus.vec_ready = 1'b0;
        exp_bus_q.push_back({2'b11, 8'h01});
        bus.cpu_cs = 1'b1;
        bus.cpu_we = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.icu_cs !== 1'b1 || bus.icu_we !== 1'b1) begin n_fail++; $display("FAIL arb_pass_strobe: got %b%b want 11", bus.icu_cs, bus.icu_we); end
        n_checks++; if (bus.icu_addr !== 2'b11 || bus.icu_data !== 8'h01) begin n_fail++; $display("FAIL arb_pass_data: got %b/%h want 11/01", bus.icu_addr, bus.icu_data); end
        n_checks++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL arb_pass_stall: got %b want 0", bus.cpu_stall); end
        tick();
        bus.cpu_cs = 1'b0;
        bus.cpu_we = 1'b0;
        exp_bus_q.push_back({2'b01, 8'h04});
        do_iret();
        repeat (4) tick();
        n_checks++; if (bus.nest_depth !== 3'd0) begin n_fail++; $display("FAIL arb_depth: got %0d want 0", bus.nest_depth); end
    endtask

    task automatic test_max_nest();
        logic [7:0] vecs [4] = '{8'h01, 8'h02, 8'h03, 8'hFF};
        int cnt;
        int req_seen = 0;
        int inta_seen = 0;
        logic [31:0] addr;
        bit ok;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_irq(vecs[i], 1'b0, cnt, addr, ok);
            @(negedge clk);
            n_checks++; if (ok !== 1'b1 || bus.nest_depth !== 3'(i + 1)) begin n_fail++; $display("FAIL nest_push%0d: got depth %0d ok %b want %0d", i, bus.nest_depth, ok, i + 1); end
            tick();
        end
        bus.intr = 1'b1;
        bus.ie = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.int_req === 1'b1) req_seen++;
            if (bus.inta === 1'b1) inta_seen++;
        end
        n_checks++; if (req_seen != 0) begin n_fail++; $display("FAIL nest_full_req: got %0d want 0", req_seen); end
        n_checks++; if (inta_seen != 0) begin n_fail++; $display("FAIL nest_full_inta: got %0d want 0", inta_seen); end
        tick();
        bus.intr = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            exp_bus_q.push_back({2'b01, 8'(1) << vecs[i][2:0]});
            do_iret();
            repeat (4) tick();
        end
        n_checks++; if (bus.nest_depth !== 3'd0) begin n_fail++; $display("FAIL nest_unwind: got %0d want 0", bus.nest_depth); end
    endtask

    task automatic test_iret_dispatch();
        int cnt;
        logic [31:0] addr;
        bit ok;
        tick();
        exp_bus_q.push_back({2'b01, 8'h40});
        drive_irq(8'h06, 1'b1, cnt, addr, ok);
        repeat (5) tick();
        n_checks++; if (ok !== 1'b1 || bus.nest_depth !== 3'd0) begin n_fail++; $display("FAIL coincide_depth: got %0d ok %b want 0", bus.nest_depth, ok); end
        n_checks++; if (bus.nest_err !== 1'b0) begin n_fail++; $display("FAIL coincide_err: got %b want 0", bus.nest_err); end
    endtask

    task automatic test_underflow();
        int wr = 0;
        tick();
        do_iret();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.icu_cs === 1'b1) wr++;
        end
        n_checks++; if (wr != 0) begin n_fail++; $display("FAIL under_write: got %0d want 0", wr); end
        n_checks++; if (bus.nest_err !== 1'b1) begin n_fail++; $display("FAIL under_err: got %b want 1", bus.nest_err); end
        n_checks++; if (bus.nest_depth !== 3'd0) begin n_fail++; $display("FAIL under_depth: got %0d want 0", bus.nest_depth); end
        repeat (10) tick();
        n_checks++; if (bus.nest_err !== 1'b1) begin n_fail++; $display("FAIL under_sticky: got %b want 1", bus.nest_err); end
    endtask

    task automatic test_reset_mid_ack();
        int vv = 0;
        tick();
        bus.vector = 8'h33;
        bus.intr = 1'b1;
        bus.ie = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.int_req === 1'b1) break;
        end
        n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL rst_ack_req: got %b want 1", bus.int_req); end
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        tick();
        rst_n = 1'b0;
        bus.intr = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.inta !== 1'b1) begin n_fail++; $display("FAIL rst_ack_second: got %b want 1", bus.inta); end
        tick();
        @(negedge clk);
        n_checks++; if (bus.inta !== 1'b0) begin n_fail++; $display("FAIL rst_ack_inta: got %b want 0", bus.inta); end
        n_checks++; if (bus.nest_depth !== 3'd0) begin n_fail++; $display("FAIL rst_ack_depth: got %0d want 0", bus.nest_depth); end
        n_checks++; if (bus.nest_err !== 1'b0) begin n_fail++; $display("FAIL rst_ack_err: got %b want 0", bus.nest_err); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.vec_valid === 1'b1 || bus.inta === 1'b1) vv++;
        end
        n_checks++; if (vv != 0) begin n_fail++; $display("FAIL rst_ack_idle: got %0d active cycles want 0", vv); end
    endtask

    initial begin
        bus.intr = 1'b0;
        bus.vector = '0;
        bus.cpu_cs = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_data = '0;
        bus.ie = 1'b0;
        bus.instr_done = 1'b0;
        bus.iret = 1'b0;
        bus.vec_ready = 1'b0;

        test_reset();
        test_basic_irq();
        test_eoi();
        test_arbitration();
        test_max_nest();
        test_iret_dispatch();
        test_underflow();
        test_reset_mid_ack();

        n_checks++; if (exp_addr_q.size() != 0) begin n_fail++; $display("FAIL sb_addr_left: got %0d want 0", exp_addr_q.size()); end
        n_checks++; if (exp_bus_q.size() != 0) begin n_fail++; $display("FAIL sb_bus_left: got %0d want 0", exp_bus_q.size()); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
